// File: rtl/multicycle_alu_if.sv
// Operation-request and register-file-writeback bundle for multicycle_alu.
// The requester holds the master modport; the ALU holds the slave modport.
interface multicycle_alu_if;
  logic       start;
  logic [2:0] op;
  logic [7:0] data1;
  logic [7:0] data2;
  logic [2:0] destreg;
  logic       ready;
  logic [7:0] writedata;
  logic [2:0] escreg;
  logic       regwrite;
  logic       done;
  logic       zero;

  modport master (
    output start, op, data1, data2, destreg,
    input  ready, writedata, escreg, regwrite, done, zero
  );

  modport slave (
    input  start, op, data1, data2, destreg,
    output ready, writedata, escreg, regwrite, done, zero
  );
endinterface

// File: rtl/multicycle_alu.sv
// Multicycle 8-bit ALU with a register-file writeback stage (IDLE -> [MUL] -> WB).
// Define ALU_MUL_EN to build the 8-iteration shift-add multiplier; otherwise MUL writes 0 with no RegWrite.
module multicycle_alu (
  input logic            clock,
  input logic            reset,
  multicycle_alu_if.slave bus
);

  typedef enum logic [2:0] {
    OP_ADD = 3'b000, OP_SUB = 3'b001, OP_AND = 3'b010, OP_OR  = 3'b011,
    OP_XOR = 3'b100, OP_SLT = 3'b101, OP_MUL = 3'b110, OP_MOV = 3'b111
  } op_t;

`ifdef ALU_MUL_EN
  typedef enum logic [1:0] {IDLE, MUL, WB} state_t;
`else
  typedef enum logic [1:0] {IDLE, WB} state_t;
`endif

  state_t     state_q, state_d;
  logic [7:0] wb_data;
  logic [2:0] wb_dst;
  logic       wb_we;
  logic       wb_entry;
  logic       we_q;

  function automatic logic [7:0] alu_op(input op_t op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_SLT:  return {7'd0, ($signed(a) < $signed(b))};
      OP_MUL:  return 8'h00;
      OP_MOV:  return b;
      default: return 8'h00;
    endcase
  endfunction

`ifdef ALU_MUL_EN
  logic       accept;
  logic [7:0] mcand_q, mplier_q, acc_q, acc_d;
  logic [2:0] dst_q;
  logic [2:0] cnt_q;

  assign accept = (state_q == IDLE) && bus.start;
  assign acc_d  = acc_q + (mplier_q[0] ? mcand_q : 8'h00);

  // Only the low 8 product bits are kept, so an 8-bit accumulator suffices.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mcand_q  <= 8'h00;
      mplier_q <= 8'h00;
      acc_q    <= 8'h00;
      dst_q    <= 3'd0;
      cnt_q    <= 3'd0;
    end else if (accept) begin
      mcand_q  <= bus.data1;
      mplier_q <= bus.data2;
      acc_q    <= 8'h00;
      dst_q    <= bus.destreg;
      cnt_q    <= 3'd0;
    end else if (state_q == MUL) begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + 3'd1;
    end
  end
`endif

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    bus.ready = 1'b0;
    bus.done  = 1'b0;
    wb_data   = alu_op(op_t'(bus.op), bus.data1, bus.data2);
    wb_dst    = bus.destreg;
    wb_we     = (bus.destreg != 3'd0);
    case (state_q)
      IDLE: begin
        bus.ready = 1'b1;
`ifndef ALU_MUL_EN
        if (op_t'(bus.op) == OP_MUL) wb_we = 1'b0;
`endif
        if (bus.start) begin
`ifdef ALU_MUL_EN
          state_d = (op_t'(bus.op) == OP_MUL) ? MUL : WB;
`else
          state_d = WB;
`endif
        end
      end
`ifdef ALU_MUL_EN
      MUL: begin
        wb_data = acc_d;
        wb_dst  = dst_q;
        wb_we   = (dst_q != 3'd0);
        if (cnt_q == 3'd7) state_d = WB;
      end
`endif
      WB: begin
        bus.done = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign wb_entry     = (state_d == WB) && (state_q != WB);
  assign bus.regwrite = bus.done & we_q;

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Writeback registers change only on WB entry, so they hold between operations.
  // NOTE: these are explicitly reset because their reset values are architecturally visible.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bus.writedata <= 8'h00;
      bus.escreg    <= 3'd0;
      bus.zero      <= 1'b1;
      we_q          <= 1'b0;
    end else if (wb_entry) begin
      bus.writedata <= wb_data;
      bus.escreg    <= wb_dst;
      bus.zero      <= (wb_data == 8'h00);
      we_q          <= wb_we;
    end
  end

endmodule

// File: tb/tb_multicycle_alu.sv
// Scoreboard bench for multicycle_alu: expectations are queued at issue and popped on Done.
// Follows the ALU_MUL_EN build macro for MUL expectations.
module tb_multicycle_alu;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  multicycle_alu_if bus ();

  multicycle_alu dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

`ifdef ALU_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  typedef struct {
    logic [7:0] data;
    logic [2:0] dst;
    logic       we;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  int   pass_cnt = 0;
  int   total    = 0;
  int   cyc      = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [7:0] model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = {8'h00, a} * {8'h00, b};
    case (op)
      3'b000:  return a + b;
      3'b001:  return a - b;
      3'b010:  return a & b;
      3'b011:  return a | b;
      3'b100:  return a ^ b;
      3'b101:  return ($signed(a) < $signed(b)) ? 8'h01 : 8'h00;
      3'b110:  return MUL_EN ? p[7:0] : 8'h00;
      default: return b;
    endcase
  endfunction

  task automatic issue(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b, input logic [2:0] d);
    exp_t e;
    bit   got_ready;
    int   lat;
    got_ready = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (bus.ready) begin
        got_ready = 1'b1;
        break;
      end
    end
    check("issue_ready", got_ready, 1);
    bus.start   = 1'b1;
    bus.op      = op;
    bus.data1   = a;
    bus.data2   = b;
    bus.destreg = d;
    lat    = (op == 3'b110 && MUL_EN) ? 9 : 1;
    e.data = model(op, a, b);
    e.dst  = d;
    e.we   = (d != 3'd0) && !(op == 3'b110 && !MUL_EN);
    e.cyc  = cyc + lat;
    sb.push_back(e);
    @(posedge clock);
    #1;
    // Scramble inputs after acceptance; the operation must not notice.
    bus.start   = 1'b0;
    bus.op      = 3'($urandom);
    bus.data1   = 8'($urandom);
    bus.data2   = 8'($urandom);
    bus.destreg = 3'($urandom);
  endtask

  always @(negedge clock) begin : monitor
    exp_t e;
    if (!reset) begin
      if (bus.regwrite && !bus.done) check("regwrite_gated", bus.regwrite, 0);
      if (bus.done) begin
        if (sb.size() == 0) begin
          check("unexpected_done", bus.done, 0);
        end else begin
          e = sb.pop_front();
          check("writedata", bus.writedata, e.data);
          check("escreg",    bus.escreg,    e.dst);
          check("regwrite",  bus.regwrite,  e.we);
          check("zero",      bus.zero,      (e.data == 8'h00));
          check("done_cycle", cyc,          e.cyc);
        end
      end
    end
  end

  task automatic check_reset_values(input string pfx);
    check({pfx, "_ready"},     bus.ready,     1);
    check({pfx, "_regwrite"},  bus.regwrite,  0);
    check({pfx, "_done"},      bus.done,      0);
    check({pfx, "_writedata"}, bus.writedata, 8'h00);
    check({pfx, "_escreg"},    bus.escreg,    3'd0);
    check({pfx, "_zero"},      bus.zero,      1);
  endtask

  initial begin
    int c0;
    bus.start   = 1'b0;
    bus.op      = 3'd0;
    bus.data1   = 8'h00;
    bus.data2   = 8'h00;
    bus.destreg = 3'd0;
    repeat (2) @(negedge clock);
    check_reset_values("rst");
    reset = 1'b0;

    // ADD wraps into the sign bit; Ready returns one cycle after WB.
    issue(3'b000, 8'h7F, 8'h01, 3'd3);
    @(negedge clock);
    check("add_ready_in_wb", bus.ready, 0);
    @(negedge clock);
    check("add_ready_after", bus.ready, 1);
    check("zero_hold", bus.zero, 0);

    // SUB to zero, then SLT back-to-back.
    issue(3'b001, 8'h05, 8'h05, 3'd2);
    c0 = cyc;
    issue(3'b101, 8'h80, 8'h01, 3'd4);
    check("back_to_back", cyc - c0, 2);

    issue(3'b010, 8'hF0, 8'h3C, 3'd1);
    issue(3'b011, 8'hF0, 8'h0C, 3'd6);
    issue(3'b100, 8'hFF, 8'h5A, 3'd7);
    issue(3'b111, 8'h00, 8'hA5, 3'd0);
    issue(3'b001, 8'h00, 8'h01, 3'd1);

    // MUL with ignored Start pulses while busy.
    issue(3'b110, 8'h0D, 8'h0B, 3'd5);
`ifdef ALU_MUL_EN
    for (int k = 0; k < 7; k++) begin
      @(negedge clock);
      check("mul_busy", bus.ready, 0);
      bus.start   = 1'b1;
      bus.op      = 3'b000;
      bus.data1   = 8'($urandom);
      bus.data2   = 8'($urandom);
      bus.destreg = 3'd7;
      @(posedge clock);
      #1;
      bus.start = 1'b0;
    end
`endif
    issue(3'b110, 8'h10, 8'h10, 3'd6);
    issue(3'b110, 8'h03, 8'h03, 3'd1);
    issue(3'b110, 8'hFF, 8'hFF, 3'd2);

    for (int i = 0; i < 24; i++)
      issue(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), 3'($urandom));

    // Reset in the middle of a MUL aborts it.
    issue(3'b110, 8'h37, 8'h29, 3'd7);
    repeat (4) @(negedge clock);
    #2;
    reset = 1'b1;
    #1;
    check_reset_values("abort");
    sb.delete();
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      check("abort_no_regwrite", bus.regwrite, 0);
    end
    check("abort_ready", bus.ready, 1);

    issue(3'b000, 8'h01, 8'h02, 3'd3);
    for (int i = 0; i < 40; i++) begin
      if (sb.size() == 0) break;
      @(negedge clock);
    end
    check("sb_drain", sb.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

// File: doc/multicycle_alu.md
MULTICYCLE_ALU -- requirements
Module: multicycle_alu

Interface
REQ-001 clock  in  1  single clock; all state updates on posedge clock.
REQ-002 reset  in  1  asynchronous, active-high reset.
REQ-003 Start  in  1  operation request; sampled only while Ready=1.
REQ-004 Op  in  3  operation code: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLT (signed), 110 MUL, 111 MOV (pass Data2).
REQ-005 Data1  in  8  operand A, from register file read port 1.
REQ-006 Data2  in  8  operand B, from register file read port 2.
REQ-007 DestReg  in  3  destination register index for writeback.
REQ-008 Ready  out  1  high only in IDLE; block accepts Start.
REQ-009 WriteData  out  8  registered result, to register file write data.
REQ-010 EscReg  out  3  registered destination index, to register file write address.
REQ-011 RegWrite  out  1  one-cycle register file write enable.
REQ-012 Done  out  1  one-cycle completion pulse, coincident with the WB cycle.
REQ-013 Zero  out  1  high when the last completed WriteData equals 8'h00.

Function
REQ-014 FSM states SHALL be IDLE, MUL, WB; encoding is free.
REQ-015 In IDLE with Start=1 at posedge N, Op, Data1, Data2, DestReg SHALL be latched; later input changes SHALL NOT affect the operation.
REQ-016 Non-MUL ops SHALL compute in the Start cycle and enter WB at posedge N; RegWrite/Done high for cycle N..N+1, return to IDLE at N+1.
REQ-017 MUL SHALL enter MUL at posedge N and run 8 shift-add iterations, one per posedge, LSB of latched Data2 first; enter WB at posedge N+8; RegWrite high for cycle N+8..N+9.
REQ-018 MUL result SHALL be the low 8 bits of the unsigned 16-bit product; upper bits discarded.
REQ-019 ADD/SUB SHALL wrap modulo 256; no carry/overflow output.
REQ-020 SLT SHALL compare latched operands as two's-complement; result 8'h01 if A<B else 8'h00.
REQ-021 WriteData, EscReg SHALL be valid and stable for the whole WB cycle so the register file captures them on the negedge inside it; they SHALL hold their value after WB until the next WB.
REQ-022 DestReg=0: operation SHALL complete normally with Done=1, but RegWrite SHALL stay 0.
REQ-023 Zero SHALL update only on entry to WB and hold otherwise.
REQ-024 Start while Ready=0 SHALL be ignored, not queued.
REQ-025 Start in the IDLE cycle following WB SHALL be accepted (back-to-back throughput: one non-MUL op per 2 cycles).

Reset
REQ-026 reset=1 SHALL immediately force IDLE, Ready=1, RegWrite=0, Done=0, WriteData=8'h00, EscReg=3'b000, Zero=1, clear all operand/accumulator state.
REQ-027 Reset during MUL or WB SHALL abort the operation with no RegWrite pulse after reset deasserts.

Configuration
REQ-028 Macro ALU_MUL_EN defined: MUL SHALL behave per REQ-017/018.
REQ-029 ALU_MUL_EN undefined: no MUL state or multiplier logic; Op 110 SHALL take the single-cycle path, WriteData=8'h00, RegWrite=0, Done=1.

Verification
REQ-030 ADD Data1=0x7F Data2=0x01 DestReg=3 Start@N -> RegWrite=1 in cycle N, WriteData=0x80, EscReg=3, Zero=0, Ready=1 at N+1.
REQ-031 SUB 0x05-0x05 DestReg=2 -> WriteData=0x00, Zero=1; then SLT 0x80,0x01 issued at N+1 -> WriteData=0x01.
REQ-032 MUL 0x0D*0x0B DestReg=5 -> RegWrite only in cycle N+8, WriteData=0x8F; MUL 0x10*0x10 -> 0x00, Zero=1; Start pulses during N+1..N+7 ignored.
REQ-033 MOV Data2=0xA5 DestReg=0 -> Done=1, RegWrite=0, WriteData=0xA5.
REQ-034 MUL started, reset pulsed at N+4 -> outputs at reset values immediately, no RegWrite for the next 10 cycles, Ready=1.
REQ-035 Build without ALU_MUL_EN, MUL 0x03*0x03 DestReg=1 -> Done in cycle N, RegWrite=0, WriteData=0x00.
